lcd_command_sequencer: RTL and testbench

//  Sequencer above the 4-bit LCD nibble transmitter. After reset it runs the
//  LCD power-on init. It then serves one requester that writes commands or

---
 rtl/lcd_command_sequencer.sv | 155 +++++++++++++++
 tb/tb_lcd_command_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_command_sequencer.sv
// Command sequencer above the 4-bit LCD nibble transmitter: runs the power-on init ROM,
// then serves one host requester, presenting one 10-bit word at a time and timing its delay.
module lcd_command_sequencer #(
  parameter int unsigned TPwrup  = 750000,
  parameter int unsigned T4100us = 205000,
  parameter int unsigned T100us  = 5000,
  parameter int unsigned T40us   = 2000,
  parameter int unsigned T1640us = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_req_i,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ack_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic [9:0] word_out_o,
  output logic       word_valid_o,
  output logic       nibble_only_o,
  input  logic       xfer_done_i
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] PwrupLast = CntW'(TPwrup - 1);
  localparam logic [CntW-1:0] Dly4100   = CntW'(T4100us);
  localparam logic [CntW-1:0] Dly100    = CntW'(T100us);
  localparam logic [CntW-1:0] Dly40     = CntW'(T40us);
  localparam logic [CntW-1:0] Dly1640   = CntW'(T1640us);

  typedef enum logic [2:0] {
    StPwrWait,
    StSend,
    StWaitXfer,
    StDelay,
    StIdle
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        step_q;
  logic [9:0]        host_word_q;
  logic              wr_ack_q;
  logic              busy_q;
  logic              init_done_q;
  logic [9:0]        word_q;
  logic              word_valid_q;
  logic              nibble_q;

  logic [9:0]        rom_word;
  logic              rom_nibble;
  logic [CntW-1:0]   rom_delay;
  logic [CntW-1:0]   host_delay;
  logic              host_slow;

  // Init ROM: first four entries are bare 8-bit-mode nibbles.
  always_comb begin
    rom_word   = 10'h000;
    rom_nibble = 1'b0;
    rom_delay  = Dly40;
    case (step_q)
      3'd0: begin rom_word = 10'h030; rom_nibble = 1'b1; rom_delay = Dly4100; end
      3'd1: begin rom_word = 10'h030; rom_nibble = 1'b1; rom_delay = Dly100;  end
      3'd2: begin rom_word = 10'h030; rom_nibble = 1'b1; rom_delay = Dly40;   end
      3'd3: begin rom_word = 10'h020; rom_nibble = 1'b1; rom_delay = Dly40;   end
      3'd4: begin rom_word = 10'h028; rom_nibble = 1'b0; rom_delay = Dly40;   end
      3'd5: begin rom_word = 10'h006; rom_nibble = 1'b0; rom_delay = Dly40;   end
      3'd6: begin rom_word = 10'h00C; rom_nibble = 1'b0; rom_delay = Dly40;   end
      3'd7: begin rom_word = 10'h001; rom_nibble = 1'b0; rom_delay = Dly1640; end
      default: begin rom_word = 10'h000; rom_nibble = 1'b0; rom_delay = Dly40; end
    endcase
  end

  // Clear (0x01) and Return Home (0x02/0x03) need the long execution time.
  always_comb begin
    host_slow  = !host_word_q[9] && (host_word_q[7:2] == 6'd0) && (host_word_q[1:0] != 2'd0);
    host_delay = host_slow ? Dly1640 : Dly40;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StPwrWait;
      cnt_q        <= '0;
      step_q       <= 3'd0;
      host_word_q  <= 10'h000;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      init_done_q  <= 1'b0;
      word_q       <= 10'h000;
      word_valid_q <= 1'b0;
      nibble_q     <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      case (state_q)
        StPwrWait: begin
          busy_q <= 1'b1;
          if (cnt_q == PwrupLast) begin
            cnt_q   <= '0;
            step_q  <= 3'd0;
            state_q <= StSend;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSend: begin
          word_q       <= init_done_q ? host_word_q : rom_word;
          nibble_q     <= init_done_q ? 1'b0 : rom_nibble;
          word_valid_q <= 1'b1;
          state_q      <= StWaitXfer;
        end
        StWaitXfer: begin
          if (xfer_done_i) begin
            word_valid_q <= 1'b0;
            cnt_q        <= init_done_q ? host_delay : rom_delay;
            state_q      <= StDelay;
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            if (init_done_q) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (step_q == 3'd7) begin
              init_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end else begin
              step_q  <= step_q + 3'd1;
              state_q <= StSend;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StIdle: begin
          if (wr_req_i) begin
            host_word_q <= {wr_rs_i, 1'b0, wr_data_i};
            wr_ack_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StSend;
          end
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign wr_ack_o      = wr_ack_q;
  assign busy_o        = busy_q;
  assign init_done_o   = init_done_q;
  assign word_out_o    = word_q;
  assign word_valid_o  = word_valid_q;
  assign nibble_only_o = nibble_q;

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Scoreboard bench for lcd_command_sequencer with shortened delays and a transmitter model
// that answers each word with xfer_done five cycles after word_valid rises.
module tb_lcd_command_sequencer;

  localparam int unsigned TPwrup = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, wr_rs;
  logic [7:0] wr_data;
  logic       wr_ack, busy, init_done;
  logic [9:0] word_out;
  logic       word_valid, nibble_only;
  logic       xfer_done;

  lcd_command_sequencer #(
    .TPwrup (TPwrup),
    .T4100us(8),
    .T100us (4),
    .T40us  (2),
    .T1640us(6)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_req_i     (wr_req),
    .wr_rs_i      (wr_rs),
    .wr_data_i    (wr_data),
    .wr_ack_o     (wr_ack),
    .busy_o       (busy),
    .init_done_o  (init_done),
    .word_out_o   (word_out),
    .word_valid_o (word_valid),
    .nibble_only_o(nibble_only),
    .xfer_done_i  (xfer_done)
  );

  always #5 clk = ~clk;

  // gap: cycles from the edge that samples xfer_done to the next word rise (init steps 0-6)
  // or to busy falling (last init step and host words).
  typedef struct {
    logic [9:0] word;
    logic       nib;
    int         gap;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic have_cur;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int xd_edge = 0;
  int gap_exp = 0;
  int words_seen = 0;
  int ack_cnt = 0;
  int xcnt = 0;
  logic first_pending = 1'b0;
  logic gap_pending = 1'b0;
  logic wv_prev = 1'b0;
  logic busy_prev = 1'b0;

  logic [9:0] init_words [8] = '{10'h030, 10'h030, 10'h030, 10'h020,
                                 10'h028, 10'h006, 10'h00C, 10'h001};
  logic       init_nib   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int         init_dly   [8] = '{8, 4, 2, 2, 2, 2, 2, 6};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('{word: init_words[i], nib: init_nib[i],
                       gap: (i < 7) ? init_dly[i] + 2 : init_dly[i] + 1});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_word_valid"}, word_valid, 0);
    check_eq({tag, "_word_out"}, word_out, 0);
    check_eq({tag, "_nibble"}, nibble_only, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_wr_ack"}, wr_ack, 0);
  endtask

  task automatic host_write(input logic rs, input logic [7:0] data, input int gap);
    logic got;
    sb_q.push_back('{word: {rs, 1'b0, data}, nib: 1'b0, gap: gap});
    wr_rs   = rs;
    wr_data = data;
    wr_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (wr_ack) begin got = 1'b1; break; end
    end
    check_eq("ack_seen", got, 1);
    wr_req = 1'b0;
    @(posedge clk); #2;
    check_eq("ack_one_cycle", wr_ack, 0);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #2;
    end
    check_eq("return_idle", busy, 0);
  endtask

  // Monitor and transmitter model share one process so xfer_done timing is unambiguous.
  initial begin : monitor
    xfer_done = 1'b0;
    have_cur  = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        xcnt = 0;
        xfer_done = 1'b0;
        wv_prev = 1'b0;
        busy_prev = 1'b0;
        gap_pending = 1'b0;
        have_cur = 1'b0;
        words_seen = 0;
      end else begin
        if (word_valid && !wv_prev) begin
          words_seen++;
          if (first_pending) begin
            check_eq("pwrup_latency", cyc - rel_cyc, TPwrup + 1);
            first_pending = 1'b0;
          end
          if (gap_pending) begin
            check_eq("gap_to_word", cyc - xd_edge, gap_exp);
            gap_pending = 1'b0;
          end
          if (sb_q.size() == 0) begin
            check_eq("unexpected_word", sb_q.size(), 1);
            have_cur = 1'b0;
          end else begin
            cur = sb_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (word_valid && have_cur) begin
          check_eq("word_out", word_out, cur.word);
          check_eq("nibble_only", nibble_only, cur.nib);
        end
        if (busy_prev && !busy && gap_pending) begin
          check_eq("gap_to_idle", cyc - xd_edge, gap_exp);
          check_eq("init_done_at_idle", init_done, 1);
          gap_pending = 1'b0;
        end
        if (wr_ack) begin
          ack_cnt++;
          check_eq("ack_after_init", init_done, 1);
        end
        xfer_done = 1'b0;
        if (xcnt != 0) begin
          xcnt--;
          if (xcnt == 0) begin
            xfer_done = 1'b1;
            xd_edge = cyc + 1;
            gap_exp = cur.gap;
            gap_pending = 1'b1;
          end
        end else if (word_valid && !wv_prev) begin
          xcnt = 4;
        end
        wv_prev = word_valid;
        busy_prev = busy;
      end
    end
  end

  initial begin : stimulus
    logic ok;
    rst_n = 1'b0;
    wr_req = 1'b0;
    wr_rs = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");

    // Request held across the whole init; must be acked exactly once afterwards.
    push_init();
    rst_n = 1'b1;
    rel_cyc = cyc;
    first_pending = 1'b1;
    host_write(1'b1, 8'h41, 3);
    check_eq("init_done", init_done, 1);
    check_eq("single_ack", ack_cnt, 1);

    host_write(1'b0, 8'h01, 7);
    host_write(1'b0, 8'h80, 3);
    host_write(1'b0, 8'h02, 7);
    host_write(1'b0, 8'h03, 7);
    host_write(1'b0, 8'h04, 3);
    host_write(1'b1, 8'h01, 3);
    check_eq("ack_count", ack_cnt, 7);
    check_eq("sb_drain_host", sb_q.size(), 0);

    // Restart init, then hit reset while step 5 is waiting for its transfer.
    rst_n = 1'b0;
    @(posedge clk); #2;
    sb_q.delete();
    push_init();
    rst_n = 1'b1;
    rel_cyc = cyc;
    first_pending = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (words_seen == 6 && word_valid) begin ok = 1'b1; break; end
    end
    check_eq("reach_step5", ok, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check_eq("sb_left_at_reset", sb_q.size(), 2);

    @(posedge clk); #2;
    sb_q.delete();
    push_init();
    rst_n = 1'b1;
    rel_cyc = cyc;
    first_pending = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (init_done) begin ok = 1'b1; break; end
    end
    check_eq("reinit_done", ok, 1);
    check_eq("reinit_idle", busy, 0);
    repeat (3) @(posedge clk);
    #2;
    check_eq("sb_drain_reinit", sb_q.size(), 0);
    check_eq("ack_count_final", ack_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
